// File: rtl/overlay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_pkg
//  Purpose  : Shared types and helpers for the full-screen overlay scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package overlay_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BANNER   = 2'd1,
        VICTORY  = 2'd2,
        GAMEOVER = 2'd3
    } overlay_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHOW  = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // Pending vector layout: bit0 banner, bit1 victory, bit2 game over.
    function automatic overlay_sel_t prio_encode(input logic [2:0] pending);
        overlay_sel_t sel;
        sel = NONE;
        if (pending[2])      sel = GAMEOVER;
        else if (pending[1]) sel = VICTORY;
        else if (pending[0]) sel = BANNER;
        return sel;
    endfunction

    function automatic logic [2:0] sel_mask(input overlay_sel_t sel);
        logic [2:0] mask;
        case (sel)
            BANNER:   mask = 3'b001;
            VICTORY:  mask = 3'b010;
            GAMEOVER: mask = 3'b100;
            default:  mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/overlay_timer.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_timer
//  Purpose  : Overlay display timer with registered expiry flag.
//             OVERLAY_SKIP_EN adds the min-elapsed flag used by skip.
//  Revision : 1.0 - initial release
// ============================================================================
module overlay_timer #(
    parameter int TIMER_W = 29
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic [TIMER_W-1:0] i_dur,
`ifdef OVERLAY_SKIP_EN
    output logic               o_min_elapsed,
`endif
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear)
            w_count_nxt = '0;
        else if (i_enable)
            w_count_nxt = r_count + TIMER_W'(1);
    end

    // Expiry is computed from the next count so it lines up with the
    // cycle in which the counter holds DUR-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            o_expire <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            o_expire <= (w_count_nxt == (i_dur - TIMER_W'(1)));
        end
    end

`ifdef OVERLAY_SKIP_EN
    assign o_min_elapsed = (r_count >= (i_dur >> 2));
`endif

endmodule
`default_nettype wire

// File: rtl/overlay_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_scheduler
//  Purpose  : Priority arbiter and frame-aligned timer for full-screen overlays.
//             Optional macro OVERLAY_SKIP_EN adds the skip_btn input.
//  Revision : 1.0 - initial release
// ============================================================================
module overlay_scheduler
    import overlay_pkg::*;
#(
    parameter int unsigned BANNER_CYCLES   = 100000000,
    parameter int unsigned VICTORY_CYCLES  = 250000000,
    parameter int unsigned GAMEOVER_CYCLES = 250000000,
    parameter int          TIMER_W         = 29
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       req_banner,
    input  logic       req_victory,
    input  logic       req_gameover,
`ifdef OVERLAY_SKIP_EN
    input  logic       skip_btn,
`endif
    output logic       overlay_active,
    output logic [1:0] overlay_sel,
    output logic       freeze_game,
    output logic       overlay_done,
    output logic [1:0] done_sel,
    output logic       game_restart
);

    sched_state_t       r_state;
    overlay_sel_t       r_cur_sel;
    logic [2:0]         r_pending;
    logic [2:0]         w_req;
    logic [2:0]         w_clr;
    overlay_sel_t       w_grant_sel;
    logic               w_grant;
    logic               w_preempt;
    logic               w_expire;
    logic               w_skip;
    logic [TIMER_W-1:0] w_dur;

    assign w_req       = {req_gameover, req_victory, req_banner};
    assign w_grant_sel = prio_encode(r_pending);
    // Only the banner can be displaced, and only by victory or game over.
    assign w_preempt   = (r_state != IDLE) && (r_cur_sel == BANNER) &&
                         (r_pending[2:1] != 2'b00);
    assign w_grant     = w_preempt || ((r_state == IDLE) && (r_pending != 3'b000));
    assign w_clr       = w_grant ? sel_mask(w_grant_sel) : 3'b000;

    always_comb begin
        case (r_cur_sel)
            BANNER:   w_dur = TIMER_W'(BANNER_CYCLES);
            VICTORY:  w_dur = TIMER_W'(VICTORY_CYCLES);
            GAMEOVER: w_dur = TIMER_W'(GAMEOVER_CYCLES);
            default:  w_dur = TIMER_W'(1);
        endcase
    end

`ifdef OVERLAY_SKIP_EN
    logic r_skip_q;
    logic w_min_elapsed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_skip_q <= 1'b0;
        else          r_skip_q <= skip_btn;
    end

    assign w_skip = (r_state == SHOW) && skip_btn && !r_skip_q && w_min_elapsed;
`else
    assign w_skip = 1'b0;
`endif

    overlay_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clear       (r_state != SHOW),
        .i_enable      (r_state == SHOW),
        .i_dur         (w_dur),
`ifdef OVERLAY_SKIP_EN
        .o_min_elapsed (w_min_elapsed),
`endif
        .o_expire      (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cur_sel      <= NONE;
            r_pending      <= 3'b000;
            overlay_active <= 1'b0;
            overlay_sel    <= 2'b00;
            freeze_game    <= 1'b0;
            overlay_done   <= 1'b0;
            done_sel       <= 2'b00;
            game_restart   <= 1'b0;
        end else begin
            // A request landing on the bit being granted survives the clear.
            r_pending    <= (r_pending & ~w_clr) | w_req;
            overlay_done <= 1'b0;
            done_sel     <= NONE;
            game_restart <= 1'b0;

            if (w_preempt) begin
                r_state        <= ARM;
                r_cur_sel      <= w_grant_sel;
                overlay_sel    <= w_grant_sel;
                overlay_active <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_grant) begin
                        r_state     <= ARM;
                        r_cur_sel   <= w_grant_sel;
                        overlay_sel <= w_grant_sel;
                        freeze_game <= 1'b1;
                    end
                    ARM: if (frame_start) begin
                        r_state        <= SHOW;
                        overlay_active <= 1'b1;
                    end
                    // A frame_start coinciding with expiry is not consumed here.
                    SHOW: if (w_expire || w_skip) begin
                        r_state <= DRAIN;
                    end
                    DRAIN: if (frame_start) begin
                        r_state        <= IDLE;
                        r_cur_sel      <= NONE;
                        overlay_sel    <= NONE;
                        overlay_active <= 1'b0;
                        freeze_game    <= 1'b0;
                        overlay_done   <= 1'b1;
                        done_sel       <= r_cur_sel;
                        game_restart   <= (r_cur_sel == VICTORY) || (r_cur_sel == GAMEOVER);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_overlay_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_overlay_scheduler
//  Purpose  : Scoreboard bench for overlay_scheduler with a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_overlay_scheduler;

    localparam int BANNER_D   = 8;
    localparam int VICTORY_D  = 20;
    localparam int GAMEOVER_D = 12;
    localparam int FRAME      = 16;
    localparam int P_IDLE     = 0;
    localparam int P_WAIT     = 1;
    localparam int P_RUN      = 2;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       frame_start  = 1'b0;
    logic       req_banner   = 1'b0;
    logic       req_victory  = 1'b0;
    logic       req_gameover = 1'b0;
`ifdef OVERLAY_SKIP_EN
    logic       skip_btn     = 1'b0;
`endif
    logic       overlay_active;
    logic [1:0] overlay_sel;
    logic       freeze_game;
    logic       overlay_done;
    logic [1:0] done_sel;
    logic       game_restart;

    overlay_scheduler #(
        .BANNER_CYCLES   (BANNER_D),
        .VICTORY_CYCLES  (VICTORY_D),
        .GAMEOVER_CYCLES (GAMEOVER_D),
        .TIMER_W         (29)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .req_banner     (req_banner),
        .req_victory    (req_victory),
        .req_gameover   (req_gameover),
`ifdef OVERLAY_SKIP_EN
        .skip_btn       (skip_btn),
`endif
        .overlay_active (overlay_active),
        .overlay_sel    (overlay_sel),
        .freeze_game    (freeze_game),
        .overlay_done   (overlay_done),
        .done_sel       (done_sel),
        .game_restart   (game_restart)
    );

    always #5 clk = ~clk;

    typedef struct { int n; logic freeze; logic active; logic [1:0] sel; } status_t;
    typedef struct { int n; logic [1:0] sel; logic restart; } done_t;

    status_t    stq[$];
    done_t      dq[$];
    int         checks   = 0;
    int         failures = 0;
    int         n_edge   = 0;

    // Model: an overlay runs from its start frame until the first frame
    // boundary strictly after its last show cycle.
    int         m_phase, m_cur, m_start, m_show_end;
    logic [2:0] m_pend;
    bit         m_skip_prev;

    function automatic int dur_of(input int s);
        case (s)
            1:       return BANNER_D;
            2:       return VICTORY_D;
            3:       return GAMEOVER_D;
            default: return 1;
        endcase
    endfunction

    function automatic int top_req(input logic [2:0] p);
        if (p[2]) return 3;
        if (p[1]) return 2;
        if (p[0]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_cur = 0; m_start = 0; m_show_end = 0;
        m_pend = 3'b000; m_skip_prev = 1'b0;
    endtask

    task automatic model_step(input int n, input logic [2:0] req, input bit fs, input bit skip);
        int         g;
        logic [2:0] clr;
        bit         rise;
        g    = top_req(m_pend);
        clr  = 3'b000;
        rise = skip && !m_skip_prev;
        if (m_phase != P_IDLE && m_cur == 1 && m_pend[2:1] != 2'b00) begin
            m_phase = P_WAIT; m_cur = g; clr[g-1] = 1'b1;
        end else if (m_phase == P_IDLE) begin
            if (g != 0) begin m_phase = P_WAIT; m_cur = g; clr[g-1] = 1'b1; end
        end else if (m_phase == P_WAIT) begin
            if (fs) begin m_phase = P_RUN; m_start = n; m_show_end = n + dur_of(m_cur); end
        end else begin
            if (rise && n > m_start && n <= m_show_end &&
                (n - m_start - 1) >= dur_of(m_cur) / 4)
                m_show_end = n;
            if (fs && n > m_show_end) begin
                dq.push_back('{n, 2'(m_cur), (m_cur >= 2)});
                m_phase = P_IDLE; m_cur = 0;
            end
        end
        m_pend      = (m_pend & ~clr) | req;
        m_skip_prev = skip;
        stq.push_back('{n, (m_phase != P_IDLE), (m_phase == P_RUN),
                        (m_phase != P_IDLE) ? 2'(m_cur) : 2'b00});
    endtask

    task automatic cycle(input logic [2:0] req, input bit rst_low, input bit skip);
        @(negedge clk);
        n_edge++;
        frame_start = (n_edge % FRAME == 0);
        {req_gameover, req_victory, req_banner} = rst_low ? 3'b000 : req;
`ifdef OVERLAY_SKIP_EN
        skip_btn = skip;
`endif
        if (rst_low) begin
            if (reset_n) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if ({freeze_game, overlay_active, overlay_sel, overlay_done, game_restart} !== 6'b0) begin
                    failures++;
                    $display("FAIL async_reset edge=%0d got freeze=%b active=%b sel=%0d done=%b restart=%b expected all 0",
                             n_edge, freeze_game, overlay_active, overlay_sel, overlay_done, game_restart);
                end
            end
            model_reset();
            stq.push_back('{n_edge, 1'b0, 1'b0, 2'b00});
        end else begin
            reset_n = 1'b1;
            model_step(n_edge, req, frame_start, skip);
        end
    endtask

    function automatic logic [2:0] dir_req(input int k);
        case (k)
            3:       return 3'b001;
            100:     return 3'b011;
            200:     return 3'b001;
            212:     return 3'b100;
            300:     return 3'b010;
            310:     return 3'b100;
            400:     return 3'b001;
            600:     return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit skip_pat(input int k);
`ifdef OVERLAY_SKIP_EN
        if (k >= 700) return ($urandom_range(0, 3) == 0);
        return (k == 611 || k == 612 || k == 615 || k == 616 || k == 617);
`else
        return (k < 0);
`endif
    endfunction

    // Monitor: compares status every edge and pops a done record on each pulse.
    initial begin
        status_t st;
        done_t   d;
        forever begin
            @(posedge clk);
            #1;
            if (stq.size() > 0) begin
                st = stq.pop_front();
                checks++;
                if (freeze_game !== st.freeze || overlay_active !== st.active || overlay_sel !== st.sel) begin
                    failures++;
                    $display("FAIL status edge=%0d got freeze=%b active=%b sel=%0d expected freeze=%b active=%b sel=%0d",
                             st.n, freeze_game, overlay_active, overlay_sel, st.freeze, st.active, st.sel);
                end
                if (overlay_done === 1'b1) begin
                    checks++;
                    if (dq.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected edge=%0d got done_sel=%0d restart=%b expected no done",
                                 st.n, done_sel, game_restart);
                    end else begin
                        d = dq.pop_front();
                        if (d.n != st.n || done_sel !== d.sel || game_restart !== d.restart) begin
                            failures++;
                            $display("FAIL done edge=%0d got done_sel=%0d restart=%b expected edge=%0d done_sel=%0d restart=%b",
                                     st.n, done_sel, game_restart, d.n, d.sel, d.restart);
                        end
                    end
                end else begin
                    if (dq.size() > 0 && dq[0].n <= st.n) begin
                        checks++;
                        failures++;
                        d = dq.pop_front();
                        $display("FAIL done_missing edge=%0d got done=0 expected done_sel=%0d", st.n, d.sel);
                    end
                    if (game_restart !== 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL restart_alone edge=%0d got restart=%b expected 0", st.n, game_restart);
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] r;
        model_reset();
        for (int k = 1; k <= 700; k++)
            cycle(dir_req(k), (k <= 2) || (k >= 420 && k <= 423), skip_pat(k));
        for (int k = 701; k <= 3700; k++) begin
            r[0] = ($urandom_range(0, 39) == 0);
            r[1] = ($urandom_range(0, 119) == 0);
            r[2] = ($urandom_range(0, 149) == 0);
            cycle(r, 1'b0, skip_pat(k));
        end
        for (int k = 3701; k <= 3900; k++)
            cycle(3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (dq.size() != 0) begin
            failures++;
            $display("FAIL done_leftover got outstanding=%0d expected 0", dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/overlay_scheduler.md
Name: overlay_scheduler

Overview:
Arbitrates the full-screen text overlays (level banner, victory, game over) that share the single 640x480 overlay render path. Latches requests from game logic and grants one overlay at a time by priority. Aligns overlay start and end to frame boundaries, times each overlay's display, and freezes gameplay while an overlay is up. Issues done and restart pulses to the top-level game FSM.

Parameters:
BANNER_CYCLES, 100000000, level-banner display time in clk cycles (2 s at 50 MHz)
VICTORY_CYCLES, 250000000, victory display time in clk cycles (5 s)
GAMEOVER_CYCLES, 250000000, game-over display time in clk cycles (5 s)
TIMER_W, 29, display-timer width; must hold the largest *_CYCLES value

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at the start of each video frame (first vblank line)
req_banner  in  1  one-cycle pulse: new level started
req_victory  in  1  one-cycle pulse: all bricks destroyed
req_gameover  in  1  one-cycle pulse: lives reached zero
overlay_active  out  1  high while the render path must draw the selected overlay
overlay_sel  out  2  0 none, 1 banner, 2 victory, 3 game over
freeze_game  out  1  high whenever the scheduler is not IDLE; stalls ball and paddle
overlay_done  out  1  one-cycle pulse when an overlay completes normally
done_sel  out  2  overlay_sel value of the completed overlay; valid with overlay_done
game_restart  out  1  one-cycle pulse after a victory or game-over overlay completes

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pending=3'b000, timer=0. All outputs are 0.
- Pending latch: each req_* pulse sets its pending bit. Bits are sticky until granted. A request arriving in the same cycle its bit is cleared stays set (set wins).
- Priority: gameover > victory > banner. Grant chooses the highest pending bit. The granted bit clears in the grant cycle.
- States:
  - IDLE: if any bit is pending -> ARM. Latch cur_sel from the grant; freeze_game=1 from ARM onward.
  - ARM: wait for frame_start -> SHOW. timer=0; overlay_active=1 from the next cycle.
  - SHOW: timer increments each cycle. When timer == DUR(cur_sel)-1 -> DRAIN.
  - DRAIN: overlay_active stays 1 until frame_start. On frame_start: overlay_active=0 and overlay_done=1 with done_sel=cur_sel (both registered, asserted the following cycle). game_restart pulses in the same cycle if cur_sel is 2 or 3. Then -> IDLE; a pending request re-arms from IDLE on the next cycle.
- Preemption:
  - A victory or gameover request while the banner is in ARM/SHOW/DRAIN aborts the banner. The next state is ARM with the new sel, and no overlay_done pulses for the banner.
  - Victory and gameover are never preempted. A gameover arriving during victory stays pending and is shown afterwards.
- overlay_sel equals cur_sel in ARM/SHOW/DRAIN and is 0 in IDLE. overlay_active is high only in SHOW/DRAIN.
- frame_start and a timer expiry in the same SHOW cycle: move to DRAIN; the frame_start is not consumed, so the overlay ends at the next frame.
- Timer arithmetic is unsigned TIMER_W bits. DUR must be >= 1; DUR=1 means exactly one SHOW cycle.
- Reset mid-overlay: immediate return to reset values; pending requests are lost.

Optional Feature:
OVERLAY_SKIP_EN. When defined, it adds input skip_btn (1 bit, already synchronised/debounced, level). A rising edge of skip_btn in SHOW, with timer >= DUR/4, forces SHOW -> DRAIN. Edges in other states are ignored. When undefined, the port is absent and overlays always run full duration.

Decomposition:
- Package overlay_pkg:
  - overlay_sel_t enum (NONE, BANNER, VICTORY, GAMEOVER, 2-bit)
  - sched_state_t enum (IDLE, ARM, SHOW, DRAIN)
  - priority-encode function for the pending vector
- Sub-module overlay_timer: TIMER_W up-counter with clear, enable, and duration input. Outputs a registered expire flag and the min_elapsed flag used for skip.

Test Plan (BANNER=8, VICTORY=20, GAMEOVER=12, frame_start every 16 cycles):
1. req_banner at cycle 3 -> freeze at cycle 4. Active begins the cycle after the next frame_start and runs 8 SHOW cycles plus the drain to the following frame_start. overlay_done=1 with done_sel=1; game_restart stays 0.
2. req_banner and req_victory in the same cycle -> victory is granted first (sel=2). overlay_done(2) and game_restart pulse, then the banner shows (sel=1) and overlay_done(1) pulses.
3. Banner in SHOW at timer=3, req_gameover arrives -> active drops and sel=3 in ARM, with no done pulse for the banner. The game-over overlay runs 12 cycles; game_restart pulses once.
4. Victory in SHOW, req_gameover arrives -> victory completes unchanged (done_sel=2), then game over is shown. Exactly two game_restart pulses total.
5. reset_n asserted low during SHOW -> all outputs are 0 asynchronously. After release, no overlay starts without a new request.
6. (OVERLAY_SKIP_EN) skip edge at timer=2 in victory -> ignored (2 < 5). Skip edge at timer=6 -> DRAIN, done at the next frame_start.
